// File: rtl/sigmoid_lut_reader_if.sv
// Read port between the sigmoid LUT reader (master) and the lookup BRAM (slave).
// Data buses carry one DATA_W element per lane.
interface sigmoid_lut_reader_if #(
  parameter int A_WID           = 15,
  parameter int SYS_ARRAY_WIDTH = 15,
  parameter int DATA_W          = 16
);
  logic                                     mem_en_o;
  logic                                     mem_we_o;
  logic                                     mem_rst_o;
  logic [A_WID-1:0]                         mem_addr_o;
  logic [SYS_ARRAY_WIDTH-1:0][DATA_W-1:0]   mem_di_o;
  logic [SYS_ARRAY_WIDTH-1:0][DATA_W-1:0]   mem_dout_i;

  modport master (
    output mem_en_o, mem_we_o, mem_rst_o, mem_addr_o, mem_di_o,
    input  mem_dout_i
  );

  modport slave (
    input  mem_en_o, mem_we_o, mem_rst_o, mem_addr_o, mem_di_o,
    output mem_dout_i
  );
endinterface

// File: rtl/sigmoid_lut_reader.sv
// Serialises a vector of pre-activations into sigmoid LUT reads, one per lane,
// and reassembles the registered BRAM results into an activated output vector.
module sigmoid_lut_reader #(
  parameter int A_WID           = 15,
  parameter int SYS_ARRAY_WIDTH = 15,
  parameter int DATA_W          = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_ni,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [SYS_ARRAY_WIDTH-1:0][DATA_W-1:0] in_data_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [SYS_ARRAY_WIDTH-1:0][DATA_W-1:0] out_data_o,
  sigmoid_lut_reader_if.master                   mem
);
  localparam int N     = SYS_ARRAY_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e                   state_r, state_nxt_s;
  logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
  logic [N-1:0][DATA_W-1:0] in_buf_r;
  logic                     load_s;
  logic                     mem_en_r, mem_en_nxt_s;
  logic [A_WID-1:0]         mem_addr_r, mem_addr_nxt_s;
  logic                     out_valid_r, out_valid_nxt_s;
  logic                     pend_r;
  logic [CNT_W-1:0]         pend_idx_r;
  logic [N-1:0][DATA_W-1:0] out_data_r;

  // Offset-binary of a signed element, truncated to the top A_WID bits.
  function automatic logic [A_WID-1:0] lut_addr(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] biased;
    biased = x ^ {1'b1, {(DATA_W-1){1'b0}}};
    return A_WID'(biased >> (DATA_W - A_WID));
  endfunction

  // Next-state and next-register values for the read sequencer.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    load_s          = 1'b0;
    mem_en_nxt_s    = 1'b0;
    mem_addr_nxt_s  = {A_WID{1'b0}};
    out_valid_nxt_s = out_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid_i) begin
          load_s         = 1'b1;
          cnt_nxt_s      = {CNT_W{1'b0}};
          state_nxt_s    = ST_ISSUE;
          mem_en_nxt_s   = 1'b1;
          mem_addr_nxt_s = lut_addr(in_data_i[0]);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          cnt_nxt_s      = cnt_r + CNT_W'(1);
          mem_en_nxt_s   = 1'b1;
          mem_addr_nxt_s = lut_addr(in_buf_r[cnt_r + CNT_W'(1)]);
        end
      end
      ST_DRAIN: begin
        state_nxt_s     = ST_HOLD;
        out_valid_nxt_s = 1'b1;
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          state_nxt_s     = ST_IDLE;
          out_valid_nxt_s = 1'b0;
        end else begin
          out_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Input capture, element counter, BRAM request and read-pending tracking.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_r      <= {CNT_W{1'b0}};
      in_buf_r   <= {(N*DATA_W){1'b0}};
      mem_en_r   <= 1'b0;
      mem_addr_r <= {A_WID{1'b0}};
      pend_r     <= 1'b0;
      pend_idx_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r      <= cnt_nxt_s;
      if (load_s) begin
        in_buf_r <= in_data_i;
      end
      mem_en_r   <= mem_en_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
      pend_r     <= (state_r == ST_ISSUE);
      pend_idx_r <= cnt_r;
    end
  end

  // Result assembly: a read issued last cycle lands in its own lane now.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(N*DATA_W){1'b0}};
    end else begin
      out_valid_r <= out_valid_nxt_s;
      if (pend_r) begin
        out_data_r[pend_idx_r] <= mem.mem_dout_i[pend_idx_r];
      end
    end
  end

  assign in_ready_o     = reset_ni & (state_r == ST_IDLE);
  assign out_valid_o    = out_valid_r;
  assign out_data_o     = out_data_r;
  assign mem.mem_en_o   = mem_en_r;
  assign mem.mem_addr_o = mem_addr_r;
  assign mem.mem_we_o   = 1'b0;
  assign mem.mem_rst_o  = 1'b0;
  assign mem.mem_di_o   = {(N*DATA_W){1'b0}};
endmodule

// File: tb/tb_sigmoid_lut_reader.sv
// Bench for sigmoid_lut_reader: N=4 and N=1 instances against a BRAM model
// whose lane k returns address+k one cycle after the request.
module tb_sigmoid_lut_reader;
  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0][DW-1:0] in_data, out_data;
  logic                 in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0][DW-1:0]   in_data1, out_data1;

  sigmoid_lut_reader_if #(.A_WID(AW), .SYS_ARRAY_WIDTH(N), .DATA_W(DW)) mif ();
  sigmoid_lut_reader_if #(.A_WID(AW), .SYS_ARRAY_WIDTH(1), .DATA_W(DW)) mif1 ();

  sigmoid_lut_reader #(.A_WID(AW), .SYS_ARRAY_WIDTH(N), .DATA_W(DW)) dut (
    .clk_i(clk), .reset_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .mem(mif)
  );

  sigmoid_lut_reader #(.A_WID(AW), .SYS_ARRAY_WIDTH(1), .DATA_W(DW)) dut1 (
    .clk_i(clk), .reset_ni(rst_n),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1),
    .mem(mif1)
  );

  // BRAM models: registered read data, lane k returns addr + k.
  always @(posedge clk) begin
    if (mif.mem_en_o) begin
      for (int k = 0; k < N; k++) mif.mem_dout_i[k] <= 16'(32'(mif.mem_addr_o) + k);
    end
    if (mif1.mem_en_o) mif1.mem_dout_i[0] <= 16'(mif1.mem_addr_o);
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_tag  = "init";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %h, expected %h", cur_tag, name, act, exp);
  endtask

  // Reference: address = top 15 bits of (x + 2^15) mod 2^16; lane k adds k.
  function automatic logic [15:0] model_addr(input logic [15:0] x);
    int unsigned biased;
    biased = (32'(x) + 32'd32768) % 32'd65536;
    return 16'(biased / 32'd2);
  endfunction

  function automatic logic [N-1:0][15:0] model_out(input logic [N-1:0][15:0] v);
    logic [N-1:0][15:0] r;
    for (int k = 0; k < N; k++) r[k] = 16'((32'(model_addr(v[k])) + k) % 65536);
    return r;
  endfunction

  // One full transaction from IDLE with cycle-exact checks and optional backpressure.
  task automatic do_vector(input logic [N-1:0][15:0] vec, input logic [N-1:0][15:0] exp_addr,
                           input logic [N-1:0][15:0] exp_out, input int bp);
    @(negedge clk);
    in_valid = 1'b1; in_data = vec; out_ready = 1'b0;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_data = {$urandom(), $urandom()};
      check("mem_en_issue", 64'(mif.mem_en_o), 64'd1);
      check("mem_addr", 64'(mif.mem_addr_o), 64'(exp_addr[k]));
      check("mem_we_rst", 64'({mif.mem_we_o, mif.mem_rst_o}), 64'd0);
      check("mem_di", 64'(mif.mem_di_o), 64'd0);
    end
    @(negedge clk);
    check("drain_mem_en", 64'(mif.mem_en_o), 64'd0);
    check("drain_addr", 64'(mif.mem_addr_o), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_data", 64'(out_data), 64'(exp_out));
    check("hold_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'(exp_out));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic back_to_back();
    logic [N-1:0][15:0] v0, v1;
    int acc[2]  = '{0, 0};
    int en_v[2] = '{0, 0};
    int n_acc   = 0;
    int rise[$];
    logic [63:0] outs[$];
    cur_tag = "b2b";
    v0 = {$urandom(), $urandom()};
    v1 = {$urandom(), $urandom()};
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (mif.mem_en_o && n_acc > 0) en_v[n_acc-1]++;
      if (out_valid) begin outs.push_back(64'(out_data)); rise.push_back(c); end
      in_valid = (n_acc < 2);
      in_data  = (n_acc == 0) ? v0 : v1;
      if (in_valid && in_ready) begin acc[n_acc] = c; n_acc++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("accepts", 64'(n_acc), 64'd2);
    check("accept_gap", 64'(acc[1] - acc[0]), 64'd7);
    check("n_outputs", 64'(outs.size()), 64'd2);
    check("en_cycles_v0", 64'(en_v[0]), 64'd4);
    check("en_cycles_v1", 64'(en_v[1]), 64'd4);
    if (outs.size() >= 2) begin
      check("out_v0", outs[0], 64'(model_out(v0)));
      check("out_v1", outs[1], 64'(model_out(v1)));
      check("rise_v0", 64'(rise[0] - acc[0]), 64'd6);
      check("rise_v1", 64'(rise[1] - acc[1]), 64'd6);
    end
  endtask

  task automatic reset_mid();
    int spurious = 0;
    cur_tag = "reset_mid";
    @(negedge clk);
    in_valid = 1'b1; in_data = {$urandom(), $urandom()};
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_mem_en", 64'(mif.mem_en_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_en", 64'(mif.mem_en_o), 64'd0);
    check("async_addr", 64'(mif.mem_addr_o), 64'd0);
    check("async_valid", 64'(out_valid), 64'd0);
    check("async_data", 64'(out_data), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || mif.mem_en_o) spurious++;
    end
    check("no_spurious", 64'(spurious), 64'd0);
  endtask

  task automatic n1_corner();
    cur_tag = "n1";
    @(negedge clk);
    in_valid1 = 1'b1; in_data1 = 16'h1234; out_ready1 = 1'b0;
    check("in_ready", 64'(in_ready1), 64'd1);
    @(posedge clk);
    #1 in_valid1 = 1'b0; in_data1 = 16'hBEEF;
    @(negedge clk);
    check("mem_en_c1", 64'(mif1.mem_en_o), 64'd1);
    check("addr_c1", 64'(mif1.mem_addr_o), 64'h491A);
    @(negedge clk);
    check("mem_en_c2", 64'(mif1.mem_en_o), 64'd0);
    check("valid_c2", 64'(out_valid1), 64'd0);
    @(negedge clk);
    check("valid_c3", 64'(out_valid1), 64'd1);
    check("data_c3", 64'(out_data1), 64'h491A);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("post_valid", 64'(out_valid1), 64'd0);
    check("post_in_ready", 64'(in_ready1), 64'd1);
  endtask

  typedef struct {
    logic [N-1:0][15:0] vec;
    logic [N-1:0][15:0] addr;
    logic [N-1:0][15:0] res;
    int                 bp;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [N-1:0][15:0] rv, ra;
    tbl[0] = '{vec: 64'hFFFF_7FFF_8000_0000, addr: 64'h3FFF_7FFF_0000_4000,
               res: 64'h4002_8001_0001_4000, bp: 10};
    tbl[1] = '{vec: 64'h0002_4000_C000_1234, addr: 64'h4001_6000_2000_491A,
               res: 64'h4004_6002_2001_491A, bp: 0};
    tbl[2] = '{vec: 64'hFFFE_0003_7FFE_8001, addr: 64'h3FFF_4001_7FFF_0000,
               res: 64'h4002_4003_8000_0000, bp: 2};

    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    cur_tag = "reset";
    check("in_ready", 64'(in_ready), 64'd0);
    check("out_valid", 64'(out_valid), 64'd0);
    check("out_data", 64'(out_data), 64'd0);
    check("mem_en", 64'(mif.mem_en_o), 64'd0);
    check("mem_addr", 64'(mif.mem_addr_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_release", 64'(in_ready), 64'd1);

    for (int i = 0; i < 3; i++) begin
      cur_tag = $sformatf("table%0d", i);
      do_vector(tbl[i].vec, tbl[i].addr, tbl[i].res, tbl[i].bp);
    end

    for (int r = 0; r < 20; r++) begin
      cur_tag = $sformatf("rand%0d", r);
      rv = {$urandom(), $urandom()};
      for (int k = 0; k < N; k++) ra[k] = model_addr(rv[k]);
      do_vector(rv, ra, model_out(rv), int'($urandom_range(0, 3)));
    end

    back_to_back();
    reset_mid();
    n1_corner();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
